// File: rtl/exc_ctrl.sv
// Exception/commit controller at the MEM->WB boundary: prioritises faults, interrupts and ERET,
// drives the CP0 exception-write port, flush and PC redirect. Optional exception counter: EXC_CNT_EN.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_is_branch,
    input  logic        m_adel_if,
    input  logic        m_ri,
    input  logic        m_ov,
    input  logic        m_sys,
    input  logic        m_bp,
    input  logic        m_adel_ld,
    input  logic        m_ades,
    input  logic [31:0] m_badaddr,
    input  logic        m_eret,
    input  logic [7:0]  intr_vect,
    input  logic [31:0] er_epc,
    output logic        cp0_we,
    output logic        cp0_bd,
    output logic        cp0_exl,
    output logic [4:0]  cp0_exc,
    output logic [31:0] cp0_epc,
    output logic [31:0] cp0_bva,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] exc_count
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state, state_nx;
    logic [31:0] flush_cnt, flush_cnt_nx;
    logic        ds_flag, ds_flag_nx;
    logic        any_exc, take, take_exc;
    logic [4:0]  exc_code;
    logic        we_nx, exl_nx, bd_nx, redirect_nx;
    logic [4:0]  exc_nx;
    logic [31:0] epc_nx, bva_nx, redirect_pc_nx;

    assign any_exc  = (intr_vect != '0) | m_adel_if | m_ri | m_ov | m_sys | m_bp | m_adel_ld | m_ades;
    assign take     = (state == IDLE) & m_valid & ~stall & (any_exc | m_eret);
    assign take_exc = take & any_exc;
    assign flush    = (state == FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            ds_flag     <= 1'b0;
            cp0_we      <= 1'b0;
            cp0_bd      <= 1'b0;
            cp0_exl     <= 1'b0;
            cp0_exc     <= '0;
            cp0_epc     <= '0;
            cp0_bva     <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state       <= state_nx;
            flush_cnt   <= flush_cnt_nx;
            ds_flag     <= ds_flag_nx;
            cp0_we      <= we_nx;
            cp0_bd      <= bd_nx;
            cp0_exl     <= exl_nx;
            cp0_exc     <= exc_nx;
            cp0_epc     <= epc_nx;
            cp0_bva     <= bva_nx;
            redirect    <= redirect_nx;
            redirect_pc <= redirect_pc_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nx     = FLUSH;
                    flush_cnt_nx = 32'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) state_nx = IDLE;
                else                 flush_cnt_nx = flush_cnt - 32'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        exc_code = '0;
        if      (intr_vect != '0) exc_code = 5'd0;
        else if (m_adel_if)       exc_code = 5'd4;
        else if (m_ri)            exc_code = 5'd10;
        else if (m_ov)            exc_code = 5'd12;
        else if (m_sys)           exc_code = 5'd8;
        else if (m_bp)            exc_code = 5'd9;
        else if (m_adel_ld)       exc_code = 5'd4;
        else if (m_ades)          exc_code = 5'd5;
    end

    // cp0_bd/exc/bva double as the shadow copies: ERET leaves them untouched so CP0 keeps its fields.
    always_comb begin
        we_nx          = 1'b0;
        redirect_nx    = 1'b0;
        exl_nx         = cp0_exl;
        bd_nx          = cp0_bd;
        exc_nx         = cp0_exc;
        epc_nx         = cp0_epc;
        bva_nx         = cp0_bva;
        redirect_pc_nx = redirect_pc;
        ds_flag_nx     = ds_flag;
        if (take) begin
            we_nx       = 1'b1;
            redirect_nx = 1'b1;
            ds_flag_nx  = 1'b0;
            if (take_exc) begin
                exl_nx         = 1'b1;
                exc_nx         = exc_code;
                bd_nx          = ds_flag;
                epc_nx         = ds_flag ? (m_pc - 32'd4) : m_pc;
                redirect_pc_nx = EXC_VECTOR;
                if (intr_vect == '0) begin
                    if (m_adel_if)                 bva_nx = m_pc;
                    else if (!m_ri && !m_ov && !m_sys && !m_bp && (m_adel_ld || m_ades))
                                                   bva_nx = m_badaddr;
                end
            end else begin
                exl_nx         = 1'b0;
                epc_nx         = er_epc;
                redirect_pc_nx = er_epc;
            end
        end else if ((state == IDLE) && m_valid && !stall) begin
            ds_flag_nx = m_is_branch;
        end
    end

`ifdef EXC_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)           exc_count <= '0;
        else if (take_exc) exc_count <= exc_count + 32'd1;
    end
`else
    assign exc_count = '0;
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: stimulus pushes expected CP0/redirect packets, a negedge monitor pops and compares.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        rst, stall, m_valid, m_is_branch;
    logic [31:0] m_pc, m_badaddr, er_epc;
    logic        m_adel_if, m_ri, m_ov, m_sys, m_bp, m_adel_ld, m_ades, m_eret;
    logic [7:0]  intr_vect;
    logic        cp0_we, cp0_bd, cp0_exl, flush, redirect;
    logic [4:0]  cp0_exc;
    logic [31:0] cp0_epc, cp0_bva, redirect_pc, exc_count;

    typedef struct {
        logic        bd;
        logic        exl;
        logic [4:0]  exc;
        logic [31:0] epc;
        logic [31:0] bva;
        logic [31:0] rpc;
    } pkt_t;

    pkt_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_exc    = 0;

    exc_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .m_valid(m_valid), .m_pc(m_pc),
        .m_is_branch(m_is_branch), .m_adel_if(m_adel_if), .m_ri(m_ri), .m_ov(m_ov),
        .m_sys(m_sys), .m_bp(m_bp), .m_adel_ld(m_adel_ld), .m_ades(m_ades),
        .m_badaddr(m_badaddr), .m_eret(m_eret), .intr_vect(intr_vect), .er_epc(er_epc),
        .cp0_we(cp0_we), .cp0_bd(cp0_bd), .cp0_exl(cp0_exl), .cp0_exc(cp0_exc),
        .cp0_epc(cp0_epc), .cp0_bva(cp0_bva), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; m_valid = 0; m_pc = '0; m_is_branch = 0; m_adel_if = 0; m_ri = 0;
        m_ov = 0; m_sys = 0; m_bp = 0; m_adel_ld = 0; m_ades = 0; m_badaddr = '0;
        m_eret = 0; intr_vect = '0; er_epc = '0;
    endtask

    function automatic pkt_t mk(logic bd, logic exl, logic [4:0] exc, logic [31:0] epc,
                                logic [31:0] bva, logic [31:0] rpc);
        pkt_t p;
        p.bd = bd; p.exl = exl; p.exc = exc; p.epc = epc; p.bva = bva; p.rpc = rpc;
        return p;
    endfunction

    // Inputs already driven; take on next edge, then check the two-cycle flush window.
    task automatic fire(input pkt_t e, input bit is_exc);
        exp_q.push_back(e);
        if (is_exc) n_exc++;
        @(posedge clk); #1; clear_inputs();
        check("flush_c1", 32'(flush), 32'd1);
        @(posedge clk); #1;
        check("flush_c2", 32'(flush), 32'd1);
        @(posedge clk); #1;
        check("flush_end", 32'(flush), 32'd0);
    endtask

    always @(negedge clk) begin
        if (cp0_we || redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_packet actual we=%b redirect=%b exc=%0d required no packet",
                         cp0_we, redirect, cp0_exc);
            end else begin
                pkt_t e;
                e = exp_q.pop_front();
                check("cp0_we",      32'(cp0_we),   32'd1);
                check("redirect",    32'(redirect), 32'd1);
                check("cp0_bd",      32'(cp0_bd),   32'(e.bd));
                check("cp0_exl",     32'(cp0_exl),  32'(e.exl));
                check("cp0_exc",     32'(cp0_exc),  32'(e.exc));
                check("cp0_epc",     cp0_epc,       e.epc);
                check("cp0_bva",     cp0_bva,       e.bva);
                check("redirect_pc", redirect_pc,   e.rpc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cnt;
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_outputs", {cp0_we, cp0_bd, cp0_exl, flush, redirect, 27'(cp0_exc)}, '0);
        check("rst_epc_bva_rpc", cp0_epc | cp0_bva | redirect_pc | exc_count, '0);

        m_valid = 1; m_pc = 32'h80000010; m_ov = 1;
        fire(mk(0, 1, 12, 32'h80000010, 32'h0, VEC), 1);

        m_valid = 1; m_pc = 32'h80000020; m_is_branch = 1;
        @(posedge clk); #1;
        clear_inputs();
        m_valid = 1; m_pc = 32'h80000024; m_ades = 1; m_badaddr = 32'h00000003;
        fire(mk(1, 1, 5, 32'h80000020, 32'h3, VEC), 1);

        m_valid = 1; m_pc = 32'h80000030; m_sys = 1; intr_vect = 8'h04;
        fire(mk(0, 1, 0, 32'h80000030, 32'h3, VEC), 1);

        m_valid = 1; m_pc = 32'h80000040; m_ov = 1;
        fire(mk(0, 1, 12, 32'h80000040, 32'h3, VEC), 1);
        m_valid = 1; m_pc = 32'h80000044; m_eret = 1; er_epc = 32'h80001000;
        fire(mk(0, 0, 12, 32'h80001000, 32'h3, 32'h80001000), 0);

        m_valid = 0; m_is_branch = 1; m_pc = 32'h8000007C;
        @(posedge clk); #1;
        clear_inputs();
        m_valid = 1; m_pc = 32'h80000080; m_bp = 1;
        fire(mk(0, 1, 9, 32'h80000080, 32'h3, VEC), 1);

        m_valid = 1; m_pc = 32'h80000071; m_adel_if = 1; m_ov = 1;
        fire(mk(0, 1, 4, 32'h80000071, 32'h80000071, VEC), 1);

        m_valid = 1; m_pc = 32'h80000084; m_adel_ld = 1; m_ades = 1; m_badaddr = 32'h00001235;
        fire(mk(0, 1, 4, 32'h80000084, 32'h00001235, VEC), 1);

        m_valid = 1; m_pc = 32'h80000050; m_ri = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("stall_no_we", 32'({cp0_we, redirect, flush}), 32'd0);
        end
        stall = 0;
        exp_q.push_back(mk(0, 1, 10, 32'h80000050, 32'h00001235, VEC));
        n_exc++;
        @(posedge clk); #1;
        clear_inputs();
        m_valid = 1; m_pc = 32'h80000060; m_adel_ld = 1; m_badaddr = 32'hDEAD0000;
        check("flush_ign1", 32'(flush), 32'd1);
        @(posedge clk); #1;
        check("flush_ign2", 32'(flush), 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        check("flush_ign_end", 32'(flush), 32'd0);
        @(posedge clk); #1;

`ifdef EXC_CNT_EN
        exp_cnt = 32'(n_exc);
`else
        exp_cnt = '0;
`endif
        check("exc_count", exc_count, exp_cnt);

        m_valid = 1; m_pc = 32'h80000090; m_ov = 1;
        exp_q.push_back(mk(0, 1, 12, 32'h80000090, 32'h00001235, VEC));
        @(posedge clk); #1;
        clear_inputs();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        n_exc = 0;
        check("rst_mid_flush", 32'({cp0_we, redirect, flush, cp0_exl, cp0_bd}), 32'd0);
        check("rst_mid_vals", cp0_epc | cp0_bva | redirect_pc | 32'(cp0_exc), 32'd0);
        check("rst_exc_count", exc_count, 32'd0);

        m_valid = 1; m_pc = 32'h800000A0; m_eret = 1; er_epc = 32'h80002000;
        fire(mk(0, 0, 0, 32'h80002000, 32'h0, 32'h80002000), 0);

        repeat (2) @(posedge clk);
        #1 check("pending_packets", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/commit controller at the MEM→WB boundary of the MIPS pipeline.
- Collects per-instruction exception flags, pending interrupts and ERET from the MEM stage.
- Prioritises them and emits a one-cycle CP0 exception-write packet, a pipeline flush and a PC redirect.
- Sits directly upstream of the CP0 register file: drives its exception-write port, and consumes its interrupt vector and ERET target.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception.
- FLUSH_CYCLES, 2, number of cycles flush stays asserted after a redirect (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  MEM stage held; nothing is taken while high
- m_valid  in  1  MEM holds a real instruction
- m_pc  in  32  PC of MEM instruction
- m_is_branch  in  1  MEM instruction is a branch/jump
- m_adel_if  in  1  fetch address error
- m_ri  in  1  reserved instruction
- m_ov  in  1  arithmetic overflow
- m_sys  in  1  syscall
- m_bp  in  1  break
- m_adel_ld  in  1  load address error
- m_ades  in  1  store address error
- m_badaddr  in  32  data address for load/store faults
- m_eret  in  1  MEM instruction is ERET
- intr_vect  in  8  pending, enabled interrupts from CP0
- er_epc  in  32  current EPC from CP0
- cp0_we  out  1  exception-write strobe to CP0
- cp0_bd  out  1  branch-delay flag
- cp0_exl  out  1  new Status.EXL
- cp0_exc  out  5  Cause.ExcCode
- cp0_epc  out  32  new EPC
- cp0_bva  out  32  new BadVAddr
- flush  out  1  kill IF..MEM
- redirect  out  1  one-cycle PC load strobe
- redirect_pc  out  32  PC load value
- exc_count  out  32  optional counter (see below)

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, state IDLE, ds_flag=0, shadow bd/exc/bva=0.
- "take" = state IDLE & m_valid & ~stall & (any flag | intr_vect≠0 | m_eret).
- Priority, highest first → ExcCode:
  - intr_vect≠0 → 0
  - adel_if → 4
  - ri → 10
  - ov → 12
  - sys → 8
  - bp → 9
  - adel_ld → 4
  - ades → 5
  - ERET is lowest; it applies only if nothing above is set.
- Delay slot:
  - ds_flag updates to m_is_branch on every non-taken retire (m_valid & ~stall & ~take).
  - ds_flag clears on take.
  - In delay slot (ds_flag=1): epc = m_pc−4, bd=1. Otherwise epc = m_pc, bd=0.
- BadVAddr: adel_if → m_pc; adel_ld/ades → m_badaddr; otherwise shadow bva is held.
- Exception take, cycle N; registered outputs in N+1:
  - cp0_we=1, exl=1, exc/bd/epc/bva as above.
  - redirect=1, redirect_pc=EXC_VECTOR.
  - Shadows updated.
- ERET take, cycle N; outputs in N+1:
  - cp0_we=1, exl=0, epc=er_epc (sampled at N).
  - bd/exc/bva taken from shadows, so CP0 fields are preserved.
  - redirect=1, redirect_pc=er_epc.
- cp0_we and redirect are single-cycle pulses.
- FSM:
  - IDLE → FLUSH on take.
  - FLUSH: flush=1 for FLUSH_CYCLES cycles starting at N+1; counter counts down; → IDLE at expiry.
  - Inputs are ignored while in FLUSH.
- Stall takes precedence: nothing is taken while stall=1; flags are re-evaluated once stall drops.
- m_valid=0 (bubble): no take, ds_flag unchanged.
- Reset mid-FLUSH: immediate return to IDLE, all outputs 0.

Optional Feature:
- Macro EXC_CNT_EN.
- Defined: exc_count increments by 1 on each exception take (not ERET), wraps at 2^32, reset 0.
- Undefined: exc_count tied to 0; no counter logic.

Test Plan:
- m_pc=0x80000010, m_ov=1, ds_flag=0 → next cycle: cp0_we=1, exc=12, epc=0x80000010, bd=0, exl=1, redirect_pc=0xBFC00380; flush high 2 cycles.
- Branch at 0x80000020 retires, then m_ades=1 with m_badaddr=0x00000003 at 0x80000024 → exc=5, bd=1, epc=0x80000020, bva=0x00000003.
- intr_vect=0x04 with m_sys=1 → exc=0 (interrupt wins).
- m_eret=1, er_epc=0x80001000, after a prior ov exception → cp0_we=1, exl=0, exc=12 (preserved), epc=0x80001000, redirect_pc=0x80001000.
- m_ri=1 while stall=1 for 3 cycles → no outputs until stall drops; take on the first unstalled cycle. A second fault arriving during FLUSH is ignored.
- EXC_CNT_EN defined: 3 exceptions plus 1 ERET → exc_count=3. rst mid-FLUSH → flush=0 next cycle, exc_count=0.
